// File: rtl/iot_event_arbiter_pkg.sv
// Shared types and sizing for the IoT event arbiter: FSM state encoding,
// default geometry and the monitor count ceiling.
package iot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/iot_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [PTR_W-1:0] o_winner
);

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(i_ptr) + i) % N_REQ;
      if (i_req[idx]) begin
        o_valid  = 1'b1;
        o_winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iot_event_arbiter.sv
// Shares the monitor's single change/on_off update port between N_REQ
// gateways, one round-robin slot per three cycles, guarding count limits.
module iot_event_arbiter
  import iot_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_on_off,
  input  logic [CNT_W-1:0] count,
  output logic             change,
  output logic             on_off,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] nack,
  output logic             busy
);

  localparam int             PTR_W   = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  arb_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_change, w_change_nxt;
  logic             r_on_off, w_on_off_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic [N_REQ-1:0] r_nack, w_nack_nxt;

  logic             w_valid;
  logic [PTR_W-1:0] w_winner;
  logic             w_dir;
  logic             w_reject;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_dir    = req_on_off[w_winner];
  assign w_reject = w_dir ? (count == CNT_MAX) : (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_change <= 1'b0;
      r_on_off <= 1'b0;
      r_ack    <= '0;
      r_nack   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_change <= w_change_nxt;
      r_on_off <= w_on_off_nxt;
      r_ack    <= w_ack_nxt;
      r_nack   <= w_nack_nxt;
    end
  end

  // Strobes default low so they last exactly the ISSUE cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_change_nxt = 1'b0;
    w_on_off_nxt = 1'b0;
    w_ack_nxt    = '0;
    w_nack_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (enable && w_valid) begin
          if (w_reject) begin
            w_nack_nxt[w_winner] = 1'b1;
          end else begin
            w_change_nxt        = 1'b1;
            w_on_off_nxt        = w_dir;
            w_ack_nxt[w_winner] = 1'b1;
          end
          w_ptr_nxt   = (w_winner == PTR_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign change = r_change;
  assign on_off = r_on_off;
  assign ack    = r_ack;
  assign nack   = r_nack;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed bench for iot_event_arbiter with a behavioural monitor counter.
module tb_iot_event_arbiter;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [3:0] req, req_on_off;
  logic [7:0] count;
  logic       change, on_off, busy;
  logic [3:0] ack, nack;
  logic       ld;
  logic [7:0] ld_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iot_event_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req        (req),
    .req_on_off (req_on_off),
    .count      (count),
    .change     (change),
    .on_off     (on_off),
    .ack        (ack),
    .nack       (nack),
    .busy       (busy)
  );

  // Monitor model: shares rst, counts up/down on each change strobe.
  always @(posedge clk) begin
    if (rst)         count <= 8'd0;
    else if (ld)     count <= ld_val;
    else if (change) count <= on_off ? count + 8'd1 : count - 8'd1;
  end

  typedef struct {
    logic       rst, en;
    logic [3:0] req, oo;
    logic       ld;
    logic [7:0] lv;
    logic       ch, on;
    logic [3:0] ack, nack;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function void add(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] oo,
                    input logic l, input logic [7:0] lv, input logic ch, input logic on,
                    input logic [3:0] a, input logic [3:0] n, input logic b, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.oo = oo; v.ld = l; v.lv = lv;
    v.ch = ch; v.on = on; v.ack = a; v.nack = n; v.busy = b; v.cnt = c;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req = 4'b1111; req_on_off = 4'b1111; ld = 1'b0; ld_val = 8'd0;

    // reset with all requesting, then first rotation from requester 0
    add(1,1,4'b1111,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd0);
    add(1,1,4'b1111,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd0);
    add(0,1,4'b1111,4'b1111,0,8'd0,   1,1,4'b0001,4'b0000,1,8'd0);
    add(0,1,4'b1111,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd1);
    add(0,1,4'b1110,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd1);
    add(0,1,4'b1110,4'b1111,0,8'd0,   1,1,4'b0010,4'b0000,1,8'd1);
    add(0,1,4'b1110,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd2);
    add(0,1,4'b1100,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd2);
    add(0,1,4'b1100,4'b1111,0,8'd0,   1,1,4'b0100,4'b0000,1,8'd2);
    add(0,1,4'b1100,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd3);
    add(0,1,4'b1000,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd3);
    add(0,1,4'b1000,4'b1111,0,8'd0,   1,1,4'b1000,4'b0000,1,8'd3);
    add(0,1,4'b1000,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd4);
    add(0,1,4'b0000,4'b1111,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd4);
    // underflow: leave from 2 at count 0 is nacked, join from 3 follows
    add(0,1,4'b0000,4'b1000,1,8'd0,   0,0,4'b0000,4'b0000,0,8'd0);
    add(0,1,4'b1100,4'b1000,0,8'd0,   0,0,4'b0000,4'b0100,1,8'd0);
    add(0,1,4'b1100,4'b1000,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd0);
    add(0,1,4'b1000,4'b1000,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd0);
    add(0,1,4'b1000,4'b1000,0,8'd0,   1,1,4'b1000,4'b0000,1,8'd0);
    add(0,1,4'b1000,4'b1000,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd1);
    add(0,1,4'b0000,4'b1000,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd1);
    // overflow: join from 1 at 255 is nacked, leave from 3 accepted
    add(0,1,4'b0000,4'b0010,1,8'd255, 0,0,4'b0000,4'b0000,0,8'd255);
    add(0,1,4'b1010,4'b0010,0,8'd0,   0,0,4'b0000,4'b0010,1,8'd255);
    add(0,1,4'b1010,4'b0010,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd255);
    add(0,1,4'b1000,4'b0010,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd255);
    add(0,1,4'b1000,4'b0010,0,8'd0,   1,0,4'b1000,4'b0000,1,8'd255);
    add(0,1,4'b1000,4'b0010,0,8'd0,   0,0,4'b0000,4'b0000,1,8'd254);
    add(0,1,4'b0000,4'b0010,0,8'd0,   0,0,4'b0000,4'b0000,0,8'd254);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en; req = tbl[i].req; req_on_off = tbl[i].oo;
      ld = tbl[i].ld; ld_val = tbl[i].lv;
      step();
      chk($sformatf("v%0d change", i), 32'(change), 32'(tbl[i].ch));
      chk($sformatf("v%0d on_off", i), 32'(on_off), 32'(tbl[i].on));
      chk($sformatf("v%0d ack", i),    32'(ack),    32'(tbl[i].ack));
      chk($sformatf("v%0d nack", i),   32'(nack),   32'(tbl[i].nack));
      chk($sformatf("v%0d busy", i),   32'(busy),   32'(tbl[i].busy));
      chk($sformatf("v%0d count", i),  32'(count),  32'(tbl[i].cnt));
    end
    ld = 1'b0;

    // continuous joins from all four at count 10: order 0,1,2,3,0
    req = 4'b0000; ld = 1'b1; ld_val = 8'd10;
    step();
    ld = 1'b0; req = 4'b1111; req_on_off = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << (s % 4);
      step();
      chk($sformatf("rr%0d ack", s), 32'(ack), 32'(exp_ack));
      chk($sformatf("rr%0d change", s), 32'(change), 32'd1);
      step();
      chk($sformatf("rr%0d change_settle", s), 32'(change), 32'd0);
      chk($sformatf("rr%0d busy_settle", s), 32'(busy), 32'd1);
      if (s == 4) req = 4'b0000;
      step();
      chk($sformatf("rr%0d change_idle", s), 32'(change), 32'd0);
      chk($sformatf("rr%0d busy_idle", s), 32'(busy), 32'd0);
    end
    chk("rr count", 32'(count), 32'd15);

    // reset during ISSUE drops the slot; pending req is served afterwards
    req = 4'b0001; req_on_off = 4'b0001;
    step();
    chk("rstiss ack", 32'(ack), 32'b0001);
    chk("rstiss change", 32'(change), 32'd1);
    rst = 1'b1;
    step();
    chk("rstiss ack_clr", 32'(ack), 32'd0);
    chk("rstiss change_clr", 32'(change), 32'd0);
    chk("rstiss busy_clr", 32'(busy), 32'd0);
    chk("rstiss count", 32'(count), 32'd0);
    rst = 1'b0;
    step();
    chk("rstiss regrant ack", 32'(ack), 32'b0001);
    chk("rstiss regrant change", 32'(change), 32'd1);
    step();
    req = 4'b0000;
    step();
    chk("rstiss count_after", 32'(count), 32'd1);

    // enable low holds pending requests; service resumes from ptr=1
    enable = 1'b0; req = 4'b0101; req_on_off = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("hold%0d ack", c), 32'(ack), 32'd0);
      chk($sformatf("hold%0d busy", c), 32'(busy), 32'd0);
    end
    enable = 1'b1;
    step();
    chk("resume ack", 32'(ack), 32'b0100);
    enable = 1'b0;
    step();
    chk("endrop busy_settle", 32'(busy), 32'd1);
    chk("endrop change", 32'(change), 32'd0);
    req = 4'b0001;
    step();
    chk("endrop busy_idle", 32'(busy), 32'd0);
    step();
    chk("endrop held ack", 32'(ack), 32'd0);
    chk("endrop held busy", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    chk("endrop resume ack", 32'(ack), 32'b0001);
    chk("endrop count", 32'(count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Controller in front of the active-IoT-device monitor counter. It shares the monitor's single change/on_off update port between N_REQ device gateways.
- Join/leave requests are arbitrated round-robin, and at most one update is issued per service slot.
- Requests that would underflow or overflow the monitor count are rejected with a nack, and no update is issued for them.
- Sits between the gateway request logic and the monitor. It reads the monitor's counter_out back as count.

Parameters:
N_REQ, 4, number of requesting gateways (2..8)
CNT_W, 8, width of monitor count; CNT_MAX = 2**CNT_W-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset (shared with monitor)
enable  in  1  1 = new grants allowed; 0 = finish current slot, then hold in IDLE
req  in  N_REQ  per-gateway request, level, held until own ack/nack
req_on_off  in  N_REQ  per-gateway direction: 1 = device joined, 0 = device left; stable while req high
count  in  CNT_W  monitor counter_out (registered in monitor)
change  out  1  to monitor: update strobe, one cycle per accepted event
on_off  out  1  to monitor: direction of current update
ack  out  N_REQ  one-hot, 1-cycle pulse: request accepted and issued
nack  out  N_REQ  one-hot, 1-cycle pulse: request rejected (count at limit)
busy  out  1  1 when state != IDLE

Behaviour:
- Reset:
  - Synchronous; rst high at an edge forces state=IDLE and ptr=0.
  - It also forces change=0, on_off=0, ack=0, nack=0 and busy=0, all from that edge.
  - rst overrides every state, so an in-flight slot is dropped and no ack/nack is produced for it.
- All outputs are registered. busy is decoded from the state register.
- FSM states are IDLE, ISSUE and SETTLE.
- IDLE:
  - If enable=1 and req!=0, pick winner g: the first set req bit searching from ptr upward, wrapping at N_REQ-1 to 0.
  - Accept/reject decision for g:
    - reject if req_on_off[g]=1 and count==CNT_MAX;
    - reject if req_on_off[g]=0 and count==0;
    - otherwise accept.
  - Next edge on accept: change=1, on_off=req_on_off[g], ack[g]=1.
  - Next edge on reject: change=0, on_off=0, nack[g]=1.
  - On that same edge, for both outcomes: ptr <= (g+1) mod N_REQ and state <= ISSUE.
  - With no request, or enable=0, the state stays IDLE and all strobes are 0.
- ISSUE, exactly 1 cycle:
  - change/ack/nack are asserted during this cycle.
  - The monitor samples change at the closing edge.
  - Next edge: change, ack and nack clear; state <= SETTLE.
- SETTLE, exactly 1 cycle:
  - Lets monitor count reflect the update.
  - Lets the requester drop req after seeing ack/nack.
  - Next edge: state <= IDLE.
- Latency and throughput:
  - req is sampled high in IDLE at edge k; the ack/nack cycle is k..k+1; count is updated at edge k+1; the arbiter is IDLE again at edge k+2.
  - Max throughput is one event per 3 cycles.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,2,..,N_REQ-1. No requester waits more than N_REQ slots.
- Simultaneous events:
  - Multiple req bits: only the round-robin winner is served; the others remain pending.
  - enable falling during ISSUE/SETTLE: the slot completes normally, then the block holds in IDLE.
- A rejected request still advances ptr, so a blocked gateway cannot starve the others.
- Requester protocol violations are unsupported: changing req_on_off or dropping req before ack/nack is undefined.

Decomposition:
- Package iot_arb_pkg holds:
  - state enum: IDLE=2'd0, ISSUE=2'd1, SETTLE=2'd2;
  - localparams for default N_REQ/CNT_W;
  - a function computing CNT_MAX.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[N_REQ-1:0], ptr.
  - Outputs: valid, winner index.
  - The top level holds the FSM, ptr and output registers.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111 -> change=ack=nack=0, busy=0 throughout. First grant after release goes to requester 0.
- Single join, count=0: req=4'b0001, req_on_off[0]=1 -> ack=4'b0001 and change=1, on_off=1, each for exactly 1 cycle, 1 cycle after sampling. busy high for 2 cycles. Monitor count goes 0->1.
- Round-robin: all four request joins continuously, count=10 -> ack order 0,1,2,3,0. Exactly one change pulse per 3 cycles. count reaches 15 after 5 slots.
- Underflow guard: count=0, req[2]=1, req_on_off[2]=0 -> nack=4'b0100 for 1 cycle, change stays 0, count stays 0. ptr advances, so a following req[3] is served next.
- Overflow guard: count=255, join from requester 1 -> nack[1]. A simultaneous leave from requester 3, served in the next slot, gets ack[3] and count goes to 254.
- Mid-operation: rst asserted during ISSUE -> change/ack clear at that edge and state returns to IDLE. Separately, enable=0 with pending req -> no grants; set enable=1 -> service resumes from the saved ptr.
